k2n_packet_arbiter: RTL
=======================

# k2n_packet_arbiter

Packet-granular round-robin arbiter sharing the single network-facing `M_AXIS_k2n` AXI4-Stream port between `NUM_PORTS` traffic sources (segment generators, loopback paths). A grant is held from the first beat of a packet until its `tlast` beat, so packets are never interleaved. The block sits between the kernel-side producers and the network kernel. Its output goes through an internal register slice for timing closure.

## Interface
- `NUM_PORTS`, 4: number of requesters; legal range 2..8.
- `AXIS_TDATA_WIDTH`, 512: tdata width in bits; tkeep is `AXIS_TDATA_WIDTH/8` bits.
- `STREAMING_TDEST_WIDTH`, 16: tdest width in bits.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `ap_clk`  in  1  sole clock; all logic is rising-edge.
- `ap_rst`  in  1  asynchronous, active-high reset.
- `S_AXIS_tdata`  in  `NUM_PORTS*AXIS_TDATA_WIDTH`  per-port data; port i occupies slice i.
- `S_AXIS_tkeep`  in  `NUM_PORTS*AXIS_TDATA_WIDTH/8`  per-port byte enables.
- `S_AXIS_tdest`  in  `NUM_PORTS*STREAMING_TDEST_WIDTH`  per-port destination.
- `S_AXIS_tlast`  in  `NUM_PORTS`  per-port end of packet.
- `S_AXIS_tvalid`  in  `NUM_PORTS`  per-port valid.
- `S_AXIS_tready`  out  `NUM_PORTS`  per-port ready; at most one bit is high at a time.
- `M_AXIS_k2n_tdata` / `_tkeep` / `_tdest` / `_tlast` / `_tvalid`  out  as above  arbitrated stream.
- `M_AXIS_k2n_tready`  in  1  downstream ready.
- `grant_port`  out  `$clog2(NUM_PORTS)`  currently or last granted port index.
- `busy`  out  1  high while a packet is in progress (state BUSY).

## Operation
- FSM states:
  - IDLE: no grant.
  - BUSY: grant locked to `grant_port`.
- In IDLE, when any `S_AXIS_tvalid` is high:
  - Select the first valid port found scanning from `last_grant+1` upward, modulo `NUM_PORTS`.
  - Register the selected index into `grant_port` and `last_grant`.
  - Next state is BUSY.
- In BUSY:
  - `S_AXIS_tready[grant_port]` equals the register-slice input ready; all other tready bits are 0.
  - Each accepted beat copies tdata, tkeep, tdest and tlast unchanged into the slice.
- On acceptance of a beat with `tlast=1`, next state is IDLE.
- Requests arriving during BUSY wait; no preemption.
- Fairness: a continuously requesting port waits at most `NUM_PORTS-1` packets.
- tvalid deasserted mid-packet by the granted port: the grant is held and the block waits.
- `busy` = (state == BUSY).

## Timing
- Reset values:
  - state IDLE; `last_grant` = `NUM_PORTS-1`, so port 0 wins the first tie.
  - `grant_port` = 0, `busy` = 0, all `S_AXIS_tready` = 0.
  - `M_AXIS_k2n_tvalid` = 0; other M outputs = 0.
- Arbitration latency:
  - First tvalid seen in IDLE at cycle N; the grant is registered at edge N+1.
  - tready is high from cycle N+1.
- Pipeline latency: an input handshake at cycle K gives `M_AXIS_k2n_tvalid` high at cycle K+1.
- Throughput:
  - One beat per cycle within a packet.
  - Exactly one idle cycle, spent in IDLE, between successive packets.
- Register slice:
  - Two-entry skid buffer; input ready is registered, with no combinational path from `M_AXIS_k2n_tready` to `S_AXIS_tready`.
  - `M_AXIS_k2n_tready` low holds the M outputs stable.
  - The slice absorbs at most 2 beats before input ready falls.
- Reset asserted mid-packet: FSM and slice clear immediately, and buffered beats are discarded. The downstream sees a truncated packet; upstream recovery is the requester's responsibility.

## Configuration
- `K2N_ARB_STATS_EN`, when defined:
  - Adds output `pkt_count`, `NUM_PORTS*32` bits wide: one 32-bit counter per port.
  - A port's counter increments on each accepted `tlast` beat from that port.
  - Counters wrap at 2^32 and reset to 0.
  - Adds input `stats_clear` (1 bit), which synchronously zeroes all counters. A clear takes precedence over a coincident increment.
- When undefined: ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package `k2n_arb_pkg`:
  - FSM state enum.
  - `MAX_PORTS = 8`.
  - Round-robin helper function `rr_next(valid, last)`.
- One sub-module, `axis_reg_slice`:
  - Two-entry skid buffer, parameterised on total payload width (tdata+tkeep+tdest+tlast).
  - Reusable by other kernels.

## Test plan
- Port 2 alone sends a 7-beat packet with tdest=5 → the output carries 7 beats with identical data, tkeep, tdest=5, and tlast on beat 7. The first M tvalid is 2 cycles after S tvalid.
- All 4 ports continuously send 3-beat packets → output port order 0,1,2,3,0,1… with no interleaving and exactly 1 idle cycle between packets.
- `M_AXIS_k2n_tready` toggles 1,0,0,1 during a 10-beat packet → no beat lost or duplicated, and M outputs stay stable while tready is low.
- Port 1 drops tvalid for 5 cycles mid-packet while port 3 requests → port 3 is not granted until port 1's tlast is accepted.
- `ap_rst` pulses during beat 4 of 8 → all outputs return to reset values within the reset window, and the next packet after reset is granted to the lowest valid port.
- With `K2N_ARB_STATS_EN`: 10 packets from port 0 and 3 from port 1 → `pkt_count` = 10 and 3. Then `stats_clear` coincident with a tlast beat → counters read 0.

Source files
------------

// File: rtl/k2n_arb_pkg.sv
// ---------------------------------------------------------------------------
// k2n_arb_pkg
// Shared definitions for the k2n packet arbiter:
//   - arb_state_e : arbiter FSM state encoding (IDLE / BUSY)
//   - MAX_PORTS   : largest supported requester count
//   - IDX_W       : width of a port index at MAX_PORTS
//   - rr_next()   : round-robin pick of the first valid port after 'last'
// ---------------------------------------------------------------------------
package k2n_arb_pkg;

   localparam int MAX_PORTS = 8;
   localparam int IDX_W     = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   // Returns the first port with valid set, scanning last+1, last+2, ...
   // modulo num_ports. Returns 'last' unchanged when nothing is valid.
   function automatic logic [IDX_W-1:0] rr_next(input logic [MAX_PORTS-1:0] valid,
                                                input logic [IDX_W-1:0]     last,
                                                input int                   num_ports);
      logic [IDX_W-1:0] sel;
      int               idx;
      sel = last;
      // Walk the distances from farthest to nearest so the nearest valid
      // port after 'last' is the final assignment and therefore wins.
      for (int k = MAX_PORTS; k >= 1; k--) begin
         if (k <= num_ports) begin
            idx = (int'(last) + k) % num_ports;
            if (valid[idx[IDX_W-1:0]]) sel = idx[IDX_W-1:0];
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// ---------------------------------------------------------------------------
// axis_reg_slice
// Two-entry skid buffer for a valid/ready stream carrying an opaque payload.
// Input ready comes straight from a flop, so there is no combinational path
// from out_ready_i back to in_ready_o. While out_ready_i is low the output
// payload and valid are held. At most two beats are absorbed before
// in_ready_o falls.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   in_data_i    upstream payload            [WIDTH]
//   in_valid_i   upstream valid
//   in_ready_o   upstream ready (registered)
//   out_data_o   downstream payload          [WIDTH]
//   out_valid_o  downstream valid
//   out_ready_i  downstream ready
// ---------------------------------------------------------------------------
module axis_reg_slice #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [WIDTH-1:0] out_data_o,
   output logic             out_valid_o,
   input  logic             out_ready_i
);

   logic [WIDTH-1:0] main_q, main_d;
   logic             main_vld_q, main_vld_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             skid_vld_q, skid_vld_d;
   logic             in_fire;
   logic             main_free;

   // Ready is simply "skid slot empty", which is itself a flop.
   assign in_ready_o = ~skid_vld_q;
   assign in_fire    = in_valid_i & ~skid_vld_q;
   assign main_free  = ~main_vld_q | out_ready_i;

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path
      // leaves it unassigned and no latch is inferred.
      main_d     = main_q;
      main_vld_d = main_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (main_free) begin
         if (skid_vld_q) begin
            // Drain the skid entry first; no input can fire while it is full.
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
         end else begin
            main_vld_d = in_fire;
            if (in_fire) main_d = in_data_i;
         end
      end else if (in_fire) begin
         // Output stalled: park the beat that was already in flight.
         skid_d     = in_data_i;
         skid_vld_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         main_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         main_q     <= main_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   // NOTE: the skid payload has no reset; it is only observed when
   // skid_vld_q is set, so clearing it would only cost reset fan-out.
   always_ff @(posedge clk_i) begin
      skid_q <= skid_d;
   end

   assign out_data_o  = main_q;
   assign out_valid_o = main_vld_q;

endmodule

// File: rtl/k2n_packet_arbiter.sv
// ---------------------------------------------------------------------------
// k2n_packet_arbiter
// Packet-granular round-robin arbiter that merges NUM_PORTS AXI4-Stream
// sources onto the single M_AXIS_k2n port. A grant is held from the first
// beat of a packet through its tlast beat, so packets never interleave.
// The merged stream passes through axis_reg_slice for timing closure.
//
// Ports:
//   ap_clk, ap_rst        clock / asynchronous active-high reset
//   S_AXIS_*              NUM_PORTS source streams, port i in slice i
//   M_AXIS_k2n_*          arbitrated output stream
//   grant_port            currently or last granted port index
//   busy                  high while a packet is in progress
//   stats_clear           (K2N_ARB_STATS_EN) synchronous clear of counters
//   pkt_count             (K2N_ARB_STATS_EN) 32-bit packet counter per port
//
// Build option: define K2N_ARB_STATS_EN to add per-port packet counters.
// ---------------------------------------------------------------------------
module k2n_packet_arbiter
   import k2n_arb_pkg::*;
#(
   parameter int NUM_PORTS             = 4,
   parameter int AXIS_TDATA_WIDTH      = 512,
   parameter int STREAMING_TDEST_WIDTH = 16
) (
   input  logic                                    ap_clk,
   input  logic                                    ap_rst,
`ifdef K2N_ARB_STATS_EN
   input  logic                                    stats_clear,
   output logic [NUM_PORTS*32-1:0]                 pkt_count,
`endif
   input  logic [NUM_PORTS*AXIS_TDATA_WIDTH-1:0]   S_AXIS_tdata,
   input  logic [NUM_PORTS*AXIS_TDATA_WIDTH/8-1:0] S_AXIS_tkeep,
   input  logic [NUM_PORTS*STREAMING_TDEST_WIDTH-1:0] S_AXIS_tdest,
   input  logic [NUM_PORTS-1:0]                    S_AXIS_tlast,
   input  logic [NUM_PORTS-1:0]                    S_AXIS_tvalid,
   output logic [NUM_PORTS-1:0]                    S_AXIS_tready,
   output logic [AXIS_TDATA_WIDTH-1:0]             M_AXIS_k2n_tdata,
   output logic [AXIS_TDATA_WIDTH/8-1:0]           M_AXIS_k2n_tkeep,
   output logic [STREAMING_TDEST_WIDTH-1:0]        M_AXIS_k2n_tdest,
   output logic                                    M_AXIS_k2n_tlast,
   output logic                                    M_AXIS_k2n_tvalid,
   input  logic                                    M_AXIS_k2n_tready,
   output logic [$clog2(NUM_PORTS)-1:0]            grant_port,
   output logic                                    busy
);

   localparam int DW = AXIS_TDATA_WIDTH;
   localparam int KW = AXIS_TDATA_WIDTH / 8;
   localparam int TW = STREAMING_TDEST_WIDTH;
   localparam int GW = $clog2(NUM_PORTS);
   localparam int PW = DW + KW + TW + 1;

   arb_state_e      state_q;
   logic [GW-1:0]   grant_q;
   logic [GW-1:0]   last_q;
   logic [GW-1:0]   sel;
   logic            in_busy;

   logic [PW-1:0]   slice_in_data;
   logic            slice_in_valid;
   logic            slice_in_ready;
   logic [PW-1:0]   slice_out_data;
   logic            s_fire;
   logic            s_last;

   assign in_busy = (state_q == ST_BUSY);
   assign sel     = GW'(rr_next(MAX_PORTS'(S_AXIS_tvalid), IDX_W'(last_q), NUM_PORTS));

   // Payload of the granted port, packed as {tdata, tkeep, tdest, tlast}.
   assign s_last         = S_AXIS_tlast[grant_q];
   assign slice_in_data  = {S_AXIS_tdata[grant_q*DW +: DW],
                            S_AXIS_tkeep[grant_q*KW +: KW],
                            S_AXIS_tdest[grant_q*TW +: TW],
                            s_last};
   assign slice_in_valid = in_busy & S_AXIS_tvalid[grant_q];
   assign s_fire         = slice_in_valid & slice_in_ready;

   // Only the granted port ever sees ready; it tracks the slice's flopped ready.
   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_tready
      assign S_AXIS_tready[i] = in_busy & (grant_q == GW'(i)) & slice_in_ready;
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         // Start "after" the top port so port 0 wins the first tie.
         last_q  <= GW'(NUM_PORTS - 1);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|S_AXIS_tvalid) begin
                  grant_q <= sel;
                  last_q  <= sel;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // Grant is released only on the accepted tlast beat; a source
               // that drops tvalid mid-packet keeps the grant.
               if (s_fire && s_last) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign grant_port = grant_q;
   assign busy       = in_busy;

   axis_reg_slice #(
      .WIDTH (PW)
   ) u_slice (
      .clk_i       (ap_clk),
      .rst_i       (ap_rst),
      .in_data_i   (slice_in_data),
      .in_valid_i  (slice_in_valid),
      .in_ready_o  (slice_in_ready),
      .out_data_o  (slice_out_data),
      .out_valid_o (M_AXIS_k2n_tvalid),
      .out_ready_i (M_AXIS_k2n_tready)
   );

   assign {M_AXIS_k2n_tdata, M_AXIS_k2n_tkeep, M_AXIS_k2n_tdest, M_AXIS_k2n_tlast} = slice_out_data;

`ifdef K2N_ARB_STATS_EN
   logic [31:0] cnt_q [NUM_PORTS];

   // Clear wins over a coincident increment; counters wrap naturally.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
      end else if (stats_clear) begin
         for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
      end else if (s_fire && s_last) begin
         cnt_q[grant_q] <= cnt_q[grant_q] + 32'd1;
      end
   end

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
      assign pkt_count[i*32 +: 32] = cnt_q[i];
   end
`endif

endmodule
